// File: rtl/bcd_seq_conv_if.sv
// ----------------------------------------------------------------------------
// bcd_seq_conv_if
//
// Handshake and result bundle for the sequential binary-to-BCD converter.
//
// Parameters:
//   BIN_W  - width of the binary operand
//   DIGITS - number of BCD result digits
//
// Signals:
//   start - request a conversion of bin (sampled only while busy=0)
//   bin   - unsigned binary operand, captured on the accepted-start edge
//   busy  - conversion in progress
//   done  - one-cycle pulse, result outputs newly updated
//   bcd   - packed BCD result, digit k at [4k+3:4k]
//   blank - leading-zero blanking mask for the display drivers
//   ovf   - result exceeded DIGITS digits (bcd holds value mod 10^DIGITS)
//
// Modports:
//   master - requester side (drives start/bin)
//   slave  - converter side (drives busy/done/bcd/blank/ovf)
// ----------------------------------------------------------------------------
interface bcd_seq_conv_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;
    logic                  ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, blank, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, blank, ovf
    );
endinterface

// File: rtl/bcd_seq_conv.sv
// ----------------------------------------------------------------------------
// bcd_seq_conv
//
// Iterative binary-to-BCD converter (shift-and-add-3 / double dabble).
// One operand bit is consumed per clock, so a conversion takes BIN_W SHIFT
// cycles followed by a single DONE cycle. A start seen in DONE is accepted
// directly, giving back-to-back conversions every BIN_W+1 cycles.
//
// Besides the BCD digits, the block produces a leading-zero blanking mask and
// a sticky overflow flag raised whenever a set bit is shifted out of the most
// significant digit.
//
// Parameters:
//   BIN_W  - operand width, 1..32
//   DIGITS - result digits; digits beyond what BIN_W needs read as 0
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - bcd_seq_conv_if.slave (start/bin in; busy/done/bcd/blank/ovf out)
// ----------------------------------------------------------------------------
module bcd_seq_conv #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_seq_conv_if.slave bus
);

    localparam int                CNT_W     = $clog2(BIN_W + 1);
    localparam int                BCD_W     = 4 * DIGITS;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BIN_W);
    // Zero result: every digit above digit 0 is blanked.
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   opnd;
    logic [BCD_W-1:0]   scratch;
    logic               sticky;

    logic [BCD_W-1:0]   bcd_q;
    logic [DIGITS-1:0]  blank_q;
    logic               ovf_q;

    logic               accept;
    logic               step;
    logic               last;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_nxt;
    logic [BIN_W-1:0]   opnd_nxt;
    logic               carry_out;
    logic               sticky_nxt;

    // Add 3 to every digit that is 5 or more, independently per nibble, so
    // that the following left shift carries correctly into the next digit.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        logic [3:0]       d;
        r = s;
        for (int k = 0; k < DIGITS; k++) begin
            d = s[4*k +: 4];
            if (d >= 4'd5) begin
                r[4*k +: 4] = d + 4'd3;
            end
        end
        return r;
    endfunction

    // blank[k] is set when digit k and all digits above it are zero.
    // Digit 0 is never blanked so a zero result still shows one '0'.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (v[4*k +: 4] == 4'd0);
            m[k]       = zero_above;
        end
        return m;
    endfunction

    // One double-dabble step: adjust, then shift {scratch, opnd} left by one.
    // The bit leaving the top digit is what feeds the sticky overflow.
    assign adj         = add3_digits(scratch);
    assign scratch_nxt = {adj[BCD_W-2:0], opnd[BIN_W-1]};
    assign carry_out   = adj[BCD_W-1];
    assign opnd_nxt    = opnd << 1;
    assign sticky_nxt  = sticky | carry_out;
    assign last        = (cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/scratch datapath and registered results. Results only move on
    // the final shift, so they hold steady through the whole SHIFT phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            opnd    <= '0;
            scratch <= '0;
            sticky  <= 1'b0;
            bcd_q   <= '0;
            blank_q <= BLANK_RST;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_LOAD;
            opnd    <= bus.bin;
            scratch <= '0;
            sticky  <= 1'b0;
        end else if (step) begin
            cnt     <= cnt - CNT_W'(1);
            opnd    <= opnd_nxt;
            scratch <= scratch_nxt;
            sticky  <= sticky_nxt;
            if (last) begin
                bcd_q   <= scratch_nxt;
                blank_q <= blank_mask(scratch_nxt);
                ovf_q   <= sticky_nxt;
            end
        end
    end

    assign bus.busy  = (state == SHIFT);
    assign bus.done  = (state == DONE);
    assign bus.bcd   = bcd_q;
    assign bus.blank = blank_q;
    assign bus.ovf   = ovf_q;

endmodule
